fifo_flagged: RTL and testbench

//   Parametrised synchronous FIFO succeeding the basic NPU buffer FIFO. Adds occupancy count,

---
 rtl/fifo_flagged.sv | 102 ++++++++++
 tb/tb_fifo_flagged.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fifo_flagged.sv
// Synchronous FIFO with occupancy count, programmable almost-full/almost-empty flags,
// sticky overflow/underflow errors and a selectable registered or fall-through read port.
module fifo_flagged #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                    CLKEXT,
    input  logic                    RST,
    input  logic                    WR_EN,
    input  logic [DATA_WIDTH-1:0]   DATA_IN,
    input  logic                    RD_EN,
    input  logic                    CLR_ERR,
    output logic [DATA_WIDTH-1:0]   DATA_OUT,
    output logic                    VALID,
    output logic                    FULL,
    output logic                    EMPTY,
    output logic                    ALMOST_FULL,
    output logic                    ALMOST_EMPTY,
    output logic [$clog2(DEPTH):0]  LEVEL,
    output logic                    OVERFLOW,
    output logic                    UNDERFLOW
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [LW-1:0]         level_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  rd_ok;
    logic                  wr_ok;

    // Access acceptance: a read is taken only when a word is stored (no empty bypass);
    // a write is taken when there is room, or when full but a read frees a slot this edge.
    // Both decisions use the occupancy registered before the edge.
    assign rd_ok = RD_EN & ~EMPTY;
    assign wr_ok = WR_EN & (~FULL | rd_ok);

    assign LEVEL        = level_q;
    assign FULL         = (level_q == DEPTH_L);
    assign EMPTY        = (level_q == '0);
    assign ALMOST_FULL  = (level_q >= AF_L);
    assign ALMOST_EMPTY = (level_q <= AE_L);
    assign OVERFLOW     = overflow_q;
    assign UNDERFLOW    = underflow_q;

    always_ff @(posedge CLKEXT) begin
        if (RST) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            level_q     <= level_q + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
            // A fresh error in the clearing cycle keeps the flag set.
            overflow_q  <= (WR_EN & ~wr_ok) | (overflow_q & ~CLR_ERR);
            underflow_q <= (RD_EN & ~rd_ok) | (underflow_q & ~CLR_ERR);
        end
    end

    // Storage is never cleared; reset only blocks the write.
    always_ff @(posedge CLKEXT) begin
        if (!RST && wr_ok) mem[wr_ptr] <= DATA_IN;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; forced to zero while nothing is stored.
            assign VALID    = ~EMPTY;
            assign DATA_OUT = EMPTY ? '0 : mem[rd_ptr];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] data_q;
            logic                  valid_q;

            always_ff @(posedge CLKEXT) begin
                if (RST) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_ok;
                    if (rd_ok) data_q <= mem[rd_ptr];
                end
            end

            assign VALID    = valid_q;
            assign DATA_OUT = data_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_flagged.sv
// Bench for fifo_flagged: registered-read and fall-through instances share one stimulus
// stream and are compared every cycle against a queue-based reference model.
module tb_fifo_flagged;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          CLKEXT = 1'b0;
    logic          RST = 1'b1;
    logic          WR_EN = 1'b0;
    logic [DW-1:0] DATA_IN = '0;
    logic          RD_EN = 1'b0;
    logic          CLR_ERR = 1'b0;

    logic [DW-1:0] dout0, dout1;
    logic          valid0, valid1, full0, full1, empty0, empty1;
    logic          af0, af1, ae0, ae1, ovf0, ovf1, unf0, unf1;
    logic [3:0]    level0, level1;

    fifo_flagged #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_reg (
        .CLKEXT(CLKEXT), .RST(RST), .WR_EN(WR_EN), .DATA_IN(DATA_IN), .RD_EN(RD_EN),
        .CLR_ERR(CLR_ERR), .DATA_OUT(dout0), .VALID(valid0), .FULL(full0), .EMPTY(empty0),
        .ALMOST_FULL(af0), .ALMOST_EMPTY(ae0), .LEVEL(level0), .OVERFLOW(ovf0), .UNDERFLOW(unf0)
    );

    fifo_flagged #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_fwft (
        .CLKEXT(CLKEXT), .RST(RST), .WR_EN(WR_EN), .DATA_IN(DATA_IN), .RD_EN(RD_EN),
        .CLR_ERR(CLR_ERR), .DATA_OUT(dout1), .VALID(valid1), .FULL(full1), .EMPTY(empty1),
        .ALMOST_FULL(af1), .ALMOST_EMPTY(ae1), .LEVEL(level1), .OVERFLOW(ovf1), .UNDERFLOW(unf1)
    );

    // clock / reset
    always #5 CLKEXT = ~CLKEXT;

    // reference model
    logic [DW-1:0] exp_q[$];
    logic          m_ovf, m_unf, m_valid;
    logic [DW-1:0] m_dout;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit rst, input bit wr, input logic [DW-1:0] d,
                              input bit rd, input bit clr);
        bit rd_ok, wr_ok;
        if (rst) begin
            exp_q.delete();
            m_ovf = 0; m_unf = 0; m_valid = 0; m_dout = '0;
            return;
        end
        rd_ok = rd && (exp_q.size() > 0);
        wr_ok = wr && ((exp_q.size() < DEPTH) || rd_ok);
        m_valid = rd_ok;
        if (rd_ok) m_dout = exp_q.pop_front();
        if (wr_ok) exp_q.push_back(d);
        m_ovf = (wr && !wr_ok) ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_unf = (rd && !rd_ok) ? 1'b1 : (clr ? 1'b0 : m_unf);
    endtask

    task automatic check_all();
        int sz = exp_q.size();
        chk("level_reg",  32'(level0), 32'(sz));
        chk("level_fwft", 32'(level1), 32'(sz));
        chk("full",   32'({full0, full1}),   {30'd0, {2{sz == DEPTH}}});
        chk("empty",  32'({empty0, empty1}), {30'd0, {2{sz == 0}}});
        chk("afull",  32'({af0, af1}),       {30'd0, {2{sz >= AF}}});
        chk("aempty", 32'({ae0, ae1}),       {30'd0, {2{sz <= AE}}});
        chk("ovf",    32'({ovf0, ovf1}),     {30'd0, {2{m_ovf}}});
        chk("unf",    32'({unf0, unf1}),     {30'd0, {2{m_unf}}});
        chk("valid_reg",  32'(valid0), 32'(m_valid));
        chk("dout_reg",   32'(dout0),  32'(m_dout));
        chk("valid_fwft", 32'(valid1), 32'(sz > 0));
        if (sz > 0) chk("dout_fwft", 32'(dout1), 32'(exp_q[0]));
    endtask

    // driver: apply inputs, clock one edge, advance model, compare
    task automatic step(input bit rst, input bit wr, input logic [DW-1:0] d,
                        input bit rd, input bit clr);
        RST = rst; WR_EN = wr; DATA_IN = d; RD_EN = rd; CLR_ERR = clr;
        @(posedge CLKEXT);
        #1;
        model_edge(rst, wr, d, rd, clr);
        check_all();
    endtask

    initial begin
        // reset
        step(1, 0, 8'h00, 0, 0);
        chk("reset_dout", 32'(dout0), 32'h0);

        // fill A0..A7, flags cross thresholds on the way
        for (int i = 0; i < DEPTH; i++) step(0, 1, 8'hA0 + 8'(i), 0, 0);
        chk("fill_level", 32'(level0), 32'd8);

        // write while full: rejected, overflow sticky until cleared
        step(0, 1, 8'hFF, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("ovf_sticky", 32'(ovf0), 32'd1);
        step(0, 0, 8'h00, 0, 1);

        // full with simultaneous read and write, then drain to show wrap
        step(0, 1, 8'hB0, 1, 0);
        chk("rw_full_pop", 32'(dout0), 32'hA0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 8'h00, 1, 0);
        chk("drain_last", 32'(dout0), 32'hB0);

        // read while empty: underflow, output holds
        step(0, 0, 8'h00, 1, 0);
        chk("underflow_hold", 32'(dout0), 32'hB0);

        // empty with simultaneous read and write: write only
        step(0, 1, 8'h11, 1, 0);
        chk("fwft_head", 32'(dout1), 32'h11);
        step(0, 0, 8'h00, 1, 1);

        // reset at level 5 with overflow set
        for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h30 + 8'(i), 0, 0);
        step(0, 1, 8'hEE, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1, 0);
        step(1, 1, 8'h55, 1, 0);
        step(0, 1, 8'h5A, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        chk("post_reset_data", 32'(dout0), 32'h5A);

        // randomized traffic with shifting write/read bias
        for (int phase = 0; phase < 6; phase++) begin
            int wr_pct = (phase % 3 == 0) ? 80 : ((phase % 3 == 1) ? 20 : 50);
            for (int i = 0; i < 150; i++) begin
                bit wr  = ($urandom_range(0, 99) < wr_pct);
                bit rd  = ($urandom_range(0, 99) < 100 - wr_pct);
                bit clr = ($urandom_range(0, 19) == 0);
                bit rst = ($urandom_range(0, 199) == 0);
                step(rst, wr, 8'($urandom), rd, clr);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
